assoc_mem64: RTL and testbench

- Synthesizable sparse associative memory that models a SystemVerilog associative array (`mem[addr]`).
- Uses a 64-bit key and 64-bit data, backed by a fully-associative table of DEPTH tag/data entries.
- Sits on a simple single-cycle write/read request bus driven by the tx_sys traffic generator, which issues wen/ren/addr/wdin and consumes rdout.
- Addresses that have never been written read as zero.

---
 rtl/assoc_mem64.sv | 139 +++++++++++++
 tb/tb_assoc_mem64.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/assoc_mem64.sv
// Sparse associative memory: a fully-associative tag/data table that reads absent keys as zero.
// Optional build macro ASSOC_ZERO_FREE_EN: writing zero to a present key frees its entry.
module assoc_mem64 #(
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wen,
    input  logic                    ren,
    input  logic [DW-1:0]           wdin,
    input  logic [AW-1:0]           addr,
    output logic [DW-1:0]           rdout,
    output logic                    rd_vld,
    output logic                    rd_hit,
    output logic                    full,
    output logic                    ovf,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    tag_q  [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [DW-1:0]    rdout_q, rdout_d;
    logic             rd_hit_q, rd_hit_d;
    logic             rd_vld_q;

    logic             hit;
    logic [IW-1:0]    hit_idx;
    logic             free_found;
    logic [IW-1:0]    free_idx;
    logic             wr_en;
    logic [IW-1:0]    wr_idx;
    logic             wr_zero;

    // Tags are unique, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == addr)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Scan downwards so the lowest-index free entry wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

`ifdef ASSOC_ZERO_FREE_EN
    assign wr_zero = (wdin == '0);
`else
    assign wr_zero = 1'b0;
`endif

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_idx  = hit_idx;
        if (wen) begin
            if (hit && wr_zero) begin
                valid_d[hit_idx] = 1'b0;
                count_d          = count_q - CW'(1);
            end else if (hit) begin
                wr_en = 1'b1;
            end else if (wr_zero) begin
                wr_en = 1'b0;
            end else if (free_found) begin
                wr_en             = 1'b1;
                wr_idx            = free_idx;
                valid_d[free_idx] = 1'b1;
                count_d           = count_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Read sees the pre-write table, giving read-before-write on a shared key.
    always_comb begin
        rdout_d  = rdout_q;
        rd_hit_d = rd_hit_q;
        if (ren) begin
            rdout_d  = hit ? data_q[hit_idx] : '0;
            rd_hit_d = hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdout_q  <= '0;
            rd_hit_q <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdout_q  <= rdout_d;
            rd_hit_q <= rd_hit_d;
            rd_vld_q <= ren;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            tag_q[wr_idx]  <= addr;
            data_q[wr_idx] <= wdin;
        end
    end

    assign rdout  = rdout_q;
    assign rd_vld = rd_vld_q;
    assign rd_hit = rd_hit_q;
    assign ovf    = ovf_q;
    assign count  = count_q;
    assign full   = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_assoc_mem64.sv
// Scoreboard bench for assoc_mem64: a reference associative array predicts every read.
module tb_assoc_mem64;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic        ren;
    logic [63:0] wdin;
    logic [63:0] addr;
    logic [63:0] rdout;
    logic        rd_vld;
    logic        rd_hit;
    logic        full;
    logic        ovf;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model [logic [63:0]];
    logic        model_ovf;
    logic [64:0] exp_q [$];
    logic [64:0] last_exp;

    assoc_mem64 #(.AW(64), .DW(64), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen    (wen),
        .ren    (ren),
        .wdin   (wdin),
        .addr   (addr),
        .rdout  (rdout),
        .rd_vld (rd_vld),
        .rd_hit (rd_hit),
        .full   (full),
        .ovf    (ovf),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_write(input logic [63:0] a, input logic [63:0] d);
        if (model.exists(a)) begin
`ifdef ASSOC_ZERO_FREE_EN
            if (d == 64'd0) begin
                model.delete(a);
                return;
            end
`endif
            model[a] = d;
        end else begin
`ifdef ASSOC_ZERO_FREE_EN
            if (d == 64'd0) return;
`endif
            if (model.num() < DEPTH) model[a] = d;
            else model_ovf = 1'b1;
        end
    endtask

    // One request per cycle; the expected read is captured before the model sees the write.
    task automatic op(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        wen  = w;
        ren  = r;
        addr = a;
        wdin = d;
        if (r) exp_q.push_back({model.exists(a), model.exists(a) ? model[a] : 64'd0});
        if (w) model_write(a, d);
    endtask

    task automatic settle();
        @(negedge clk);
        wen  = 1'b0;
        ren  = 1'b0;
        addr = 'x;
        wdin = 'x;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 64'(count), 64'(model.num()));
        check({tag, "_full"},  64'(full),  64'(model.num() == DEPTH));
        check({tag, "_ovf"},   64'(ovf),   64'(model_ovf));
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        model.delete();
        model_ovf = 1'b0;
        last_exp  = '0;
    endtask

    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (rd_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rd_vld_unexpected", 64'(rd_vld), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    check("rd_data", rdout, e[63:0]);
                    check("rd_hit", 64'(rd_hit), 64'(e[64]));
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        wen       = 1'b0;
        ren       = 1'b0;
        addr      = '0;
        wdin      = '0;
        model_ovf = 1'b0;
        last_exp  = '0;

        // Reset with a request pending in its last cycle: it must be ignored.
        repeat (9) @(negedge clk);
        wen  = 1'b1;
        ren  = 1'b1;
        addr = 64'h1234;
        wdin = 64'h5;
        @(negedge clk);
        check("rst_rd_vld", 64'(rd_vld), 64'd0);
        check("rst_rdout", rdout, 64'd0);
        check("rst_rd_hit", 64'(rd_hit), 64'd0);
        rst_n = 1'b1;
        wen   = 1'b0;
        ren   = 1'b0;
        check_status("rst");

        op(1'b0, 1'b1, 64'h1234, 64'd0);
        settle();
        check_status("after_rst_read");

        op(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF);
        op(1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'd0);
        settle();
        check_status("basic");

        op(1'b1, 1'b0, 64'h10, 64'hAA);
        op(1'b1, 1'b0, 64'h10, 64'hBB);
        settle();
        check_status("overwrite");
        op(1'b0, 1'b1, 64'h10, 64'd0);
        settle();
        repeat (2) @(negedge clk);
        check("hold_rdout", rdout, last_exp[63:0]);
        check("hold_rd_hit", 64'(rd_hit), 64'(last_exp[64]));
        check("hold_rd_vld", 64'(rd_vld), 64'd0);
        op(1'b0, 1'b1, 64'h11, 64'd0);
        settle();

        do_reset(2);
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 64'h100 + 64'(i), 64'h1000 + 64'(i));
        settle();
        check_status("fill");
        op(1'b1, 1'b0, 64'h200, 64'h77);
        op(1'b0, 1'b1, 64'h200, 64'd0);
        settle();
        check_status("overflow");
        op(1'b1, 1'b0, 64'h105, 64'h55);
        for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 64'h100 + 64'(i), 64'd0);
        settle();
        check_status("after_full_update");

        do_reset(2);
        op(1'b1, 1'b0, 64'h40, 64'h5);
        op(1'b1, 1'b1, 64'h40, 64'h9);
        op(1'b0, 1'b1, 64'h40, 64'd0);
        op(1'b1, 1'b1, 64'h41, 64'h3);
        op(1'b0, 1'b1, 64'h41, 64'd0);
        settle();
        check_status("simul");

        do_reset(2);
        for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 64'h100 + 64'(i), 64'h1000 + 64'(i));
        op(1'b1, 1'b0, 64'h103, 64'd0);
        settle();
        check_status("zero_write");
        op(1'b1, 1'b0, 64'h300, 64'h7);
        op(1'b0, 1'b1, 64'h300, 64'd0);
        op(1'b0, 1'b1, 64'h103, 64'd0);
        op(1'b0, 1'b1, 64'h104, 64'd0);
        settle();
        check_status("zero_reuse");

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
